test_pattern_gen: RTL and testbench



---
 rtl/test_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_test_pattern_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// test_pattern_gen
//
// Multi-mode video test-pattern generator. It sits behind an hvsync-style
// timing generator and turns display_on/hpos/vpos into a registered RGB pixel.
// Four patterns are available: full-height colour bars, SMPTE-style split
// bars, an animated checkerboard and a crosshair whose vertical line moves one
// column per frame. Mode requests are acknowledged immediately but only take
// effect on a frame boundary, so every frame is drawn with a single mode.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   display_on   visible-region flag from the sync generator
//   hpos, vpos   current pixel column / line
//   mode_req     requested mode (0 bars, 1 SMPTE split, 2 checker, 3 crosshair)
//   mode_valid   mode_req is valid this cycle
//   mode_ack     one-cycle pulse, the cycle after a request is seen
//   active_mode  mode currently being drawn
//   frame_count  completed-frame counter, wraps at 255
//   rgb          {R,G,B}, COLOR_BITS per channel, one cycle behind hpos/vpos
// -----------------------------------------------------------------------------
module test_pattern_gen #(
  parameter int H_DISPLAY  = 256,
  parameter int V_DISPLAY  = 240,
  parameter int POS_BITS   = 9,
  parameter int NUM_BARS   = 7,
  parameter int COLOR_BITS = 1,
  parameter int CELL_LOG2  = 3,
  parameter int ANIM_LOG2  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    display_on,
  input  logic [POS_BITS-1:0]     hpos,
  input  logic [POS_BITS-1:0]     vpos,
  input  logic [1:0]              mode_req,
  input  logic                    mode_valid,
  output logic                    mode_ack,
  output logic [1:0]              active_mode,
  output logic [7:0]              frame_count,
  output logic [3*COLOR_BITS-1:0] rgb
);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_SMPTE   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_CROSS   = 2'd3
  } mode_e;

  localparam int BAR_WIDTH = H_DISPLAY / NUM_BARS;

  localparam logic [POS_BITS-1:0] BAR_LAST_PX = POS_BITS'(BAR_WIDTH - 1);
  localparam logic [2:0]          LAST_BAR    = 3'(NUM_BARS - 1);
  localparam logic [POS_BITS-1:0] LAST_COL    = POS_BITS'(H_DISPLAY - 1);
  localparam logic [POS_BITS-1:0] LAST_LINE   = POS_BITS'(V_DISPLAY - 1);
  localparam logic [POS_BITS-1:0] SPLIT_LINE  = POS_BITS'((2 * V_DISPLAY) / 3);
  localparam logic [POS_BITS-1:0] MID_LINE    = POS_BITS'(V_DISPLAY / 2);
  localparam logic [POS_BITS-1:0] POS_ONE     = POS_BITS'(1);

  // Bar index to 1-bit {R,G,B}: white, yellow, cyan, green, magenta, red,
  // blue, black for indices 0..7.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

  // Each 1-bit channel becomes all-ones or all-zeros at the output depth.
  function automatic logic [3*COLOR_BITS-1:0] expand(input logic [2:0] c);
    return {{COLOR_BITS{c[2]}}, {COLOR_BITS{c[1]}}, {COLOR_BITS{c[0]}}};
  endfunction

  logic [POS_BITS-1:0]     bar_px_q,    bar_px_d;
  logic [2:0]              bar_idx_q,   bar_idx_d;
  mode_e                   pending_q,   pending_d;
  mode_e                   active_q,    active_d;
  logic [7:0]              frame_q,     frame_d;
  logic [POS_BITS-1:0]     cross_x_q,   cross_x_d;
  logic                    mode_ack_q;
  logic [3*COLOR_BITS-1:0] rgb_q,       rgb_d;

  logic       frame_end;
  logic [2:0] pixel;

  assign frame_end = display_on && (hpos == LAST_COL) && (vpos == LAST_LINE);

  // Bar position tracking. The counters restart at every blanking interval,
  // so the pixel left of the first bar boundary is always bar 0. Remainder
  // pixels past NUM_BARS*BAR_WIDTH stay in the last bar via saturation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    bar_px_d  = '0;
    bar_idx_d = '0;
    if (display_on) begin
      if (bar_px_q == BAR_LAST_PX) begin
        bar_idx_d = (bar_idx_q == LAST_BAR) ? bar_idx_q : bar_idx_q + 3'd1;
      end else begin
        bar_px_d  = bar_px_q + POS_ONE;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  // Pixel colour from the current-cycle state. The frame-end pixel is drawn
  // here with the old mode/phase/cross_x because the updates below only land
  // at the next edge.
  always_comb begin
    pixel = 3'b000;
    case (active_q)
      MODE_BARS: pixel = bar_colour(bar_idx_q);
      MODE_SMPTE: begin
        if (vpos < SPLIT_LINE) begin
          pixel = bar_colour(bar_idx_q);
        end else if (!bar_idx_q[0]) begin
          // Lower band: even bars mirror the top row, odd bars are black.
          pixel = bar_colour(LAST_BAR - bar_idx_q);
        end
      end
      MODE_CHECKER:
        pixel = {3{hpos[CELL_LOG2] ^ vpos[CELL_LOG2] ^ frame_q[ANIM_LOG2]}};
      MODE_CROSS:
        pixel = {3{(hpos == cross_x_q) || (vpos == MID_LINE)}};
      default: pixel = 3'b000;
    endcase
  end

  // Mode handshake and per-frame state.
  always_comb begin
    pending_d = mode_valid ? mode_e'(mode_req) : pending_q;
    active_d  = active_q;
    frame_d   = frame_q;
    cross_x_d = cross_x_q;
    if (frame_end) begin
      // pending_d already carries a same-cycle request, so it wins here.
      active_d  = pending_d;
      frame_d   = frame_q + 8'd1;
      cross_x_d = (cross_x_q == LAST_COL) ? '0 : cross_x_q + POS_ONE;
    end
    rgb_d = display_on ? expand(pixel) : '0;
  end

  // NOTE: reset is synchronous here, so it is sampled only inside the clocked
  // branch and never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_px_q   <= '0;
      bar_idx_q  <= '0;
      pending_q  <= MODE_BARS;
      active_q   <= MODE_BARS;
      frame_q    <= '0;
      cross_x_q  <= '0;
      mode_ack_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      bar_px_q   <= bar_px_d;
      bar_idx_q  <= bar_idx_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      frame_q    <= frame_d;
      cross_x_q  <= cross_x_d;
      mode_ack_q <= mode_valid;
      rgb_q      <= rgb_d;
    end
  end

  assign mode_ack    = mode_ack_q;
  assign active_mode = active_q;
  assign frame_count = frame_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_test_pattern_gen
//
// Directed bench for test_pattern_gen with default parameters. The driver
// applies one pixel per clock just after the falling edge and pushes the
// expected response, tagged with the cycle it must appear in, onto a
// scoreboard queue. A separate monitor samples on every falling edge and
// compares whatever entries are due.
// -----------------------------------------------------------------------------
module tb_test_pattern_gen;

  localparam int POS_BITS = 9;

  logic                clk = 1'b0;
  logic                reset;
  logic                display_on;
  logic [POS_BITS-1:0] hpos;
  logic [POS_BITS-1:0] vpos;
  logic [1:0]          mode_req;
  logic                mode_valid;
  logic                mode_ack;
  logic [1:0]          active_mode;
  logic [7:0]          frame_count;
  logic [2:0]          rgb;

  always #5 clk = ~clk;

  test_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .mode_req    (mode_req),
    .mode_valid  (mode_valid),
    .mode_ack    (mode_ack),
    .active_mode (active_mode),
    .frame_count (frame_count),
    .rgb         (rgb)
  );

  localparam logic [1:0] K_RGB   = 2'd0;
  localparam logic [1:0] K_ACK   = 2'd1;
  localparam logic [1:0] K_MODE  = 2'd2;
  localparam logic [1:0] K_FRAME = 2'd3;

  typedef struct packed {
    int         due;
    logic [1:0] kind;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t   sb_q[$];
  string      name_q[$];
  logic [2:0] exp_pix[int];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops every entry that is due this cycle and compares it.
  sb_item_t   mon_item;
  string      mon_name;
  logic [7:0] mon_act;
  initial forever begin
    @(negedge clk);
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_item = sb_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_item.kind)
        K_RGB:   mon_act = 8'(rgb);
        K_ACK:   mon_act = 8'(mode_ack);
        K_MODE:  mon_act = 8'(active_mode);
        default: mon_act = frame_count;
      endcase
      n_checks++;
      if (mon_item.due != cyc) begin
        n_fail++;
        $display("FAIL %s: sample missed, due cycle %0d but now %0d",
                 mon_name, mon_item.due, cyc);
      end else if (mon_act !== mon_item.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", mon_name, mon_act, mon_item.exp);
      end
    end
  end

  // Expected response to the inputs just driven: visible one cycle later.
  function automatic void push(input string name, input logic [1:0] kind,
                               input logic [7:0] exp);
    sb_item_t it;
    it.due  = cyc + 1;
    it.kind = kind;
    it.exp  = exp;
    sb_q.push_back(it);
    name_q.push_back(name);
  endfunction

  task automatic drive(input logic rst, input logic don, input int h, input int v,
                       input logic mv, input logic [1:0] mr);
    @(negedge clk);
    reset      = rst;
    display_on = don;
    hpos       = POS_BITS'(h);
    vpos       = POS_BITS'(v);
    mode_valid = mv;
    mode_req   = mr;
  endtask

  task automatic pixel(input int h, input int v, input logic [2:0] e, input string tag);
    drive(1'b0, 1'b1, h, v, 1'b0, 2'd0);
    push($sformatf("%s_px%0d_%0d", tag, h, v), K_RGB, 8'(e));
  endtask

  // One full visible line after a short blank; pixels listed in exp_pix are
  // checked, and the first blank pixel afterwards must be black.
  task automatic sweep_line(input int v, input string tag);
    drive(1'b0, 1'b0, 0, v, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 0, v, 1'b0, 2'd0);
    for (int h = 0; h < 256; h++) begin
      drive(1'b0, 1'b1, h, v, 1'b0, 2'd0);
      if (exp_pix.exists(h)) push($sformatf("%s_v%0d_h%0d", tag, v, h), K_RGB, 8'(exp_pix[h]));
    end
    drive(1'b0, 1'b0, 0, v, 1'b0, 2'd0);
    push($sformatf("%s_v%0d_blank", tag, v), K_RGB, 8'd0);
  endtask

  // Blank, frame-end pixel, blank. Checks the state on both sides of the edge.
  task automatic frame_end(input logic mv, input logic [1:0] mr,
                           input logic [1:0] old_mode, input logic [1:0] new_mode,
                           input logic [7:0] new_frame);
    logic [7:0] prev;
    prev = new_frame - 8'd1;
    drive(1'b0, 1'b0, 0, 239, 1'b0, 2'd0);
    push($sformatf("pre_fe%0d_mode", new_frame), K_MODE, 8'(old_mode));
    push($sformatf("pre_fe%0d_frame", new_frame), K_FRAME, prev);
    push($sformatf("pre_fe%0d_ack", new_frame), K_ACK, 8'd0);
    drive(1'b0, 1'b1, 255, 239, mv, mr);
    push($sformatf("fe%0d_mode", new_frame), K_MODE, 8'(new_mode));
    push($sformatf("fe%0d_frame", new_frame), K_FRAME, new_frame);
    push($sformatf("fe%0d_ack", new_frame), K_ACK, 8'(mv));
    drive(1'b0, 1'b0, 0, 0, 1'b0, 2'd0);
  endtask

  task automatic load_mode0_table();
    exp_pix.delete();
    exp_pix[0]   = 3'b111;  exp_pix[35]  = 3'b111;
    exp_pix[36]  = 3'b110;  exp_pix[71]  = 3'b110;
    exp_pix[72]  = 3'b011;  exp_pix[108] = 3'b010;
    exp_pix[144] = 3'b101;  exp_pix[180] = 3'b100;
    exp_pix[216] = 3'b001;  exp_pix[251] = 3'b001;
    exp_pix[252] = 3'b001;  exp_pix[255] = 3'b001;
  endtask

  task automatic load_cross_table(input int col, input logic all_white);
    exp_pix.delete();
    for (int h = 0; h < 256; h++) exp_pix[h] = (all_white || h == col) ? 3'b111 : 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; display_on = 1'b0; hpos = '0; vpos = '0;
    mode_req = 2'd0; mode_valid = 1'b0;

    // Reset dominates a visible pixel and a valid request.
    drive(1'b1, 1'b1, 0, 0, 1'b1, 2'd2);
    push("rst_rgb", K_RGB, 8'd0);
    push("rst_ack", K_ACK, 8'd0);
    push("rst_mode", K_MODE, 8'd0);
    push("rst_frame", K_FRAME, 8'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 2'd0);

    // Mode 0 colour bars.
    load_mode0_table();
    sweep_line(10, "m0");

    // Request mode 1 mid-frame; it only takes effect after the frame end.
    drive(1'b0, 1'b0, 0, 20, 1'b1, 2'd1);
    push("req1_ack", K_ACK, 8'd1);
    drive(1'b0, 1'b0, 0, 20, 1'b0, 2'd0);
    push("req1_ack_drop", K_ACK, 8'd0);
    push("req1_mode_held", K_MODE, 8'd0);
    frame_end(1'b0, 2'd0, 2'd0, 2'd1, 8'd1);

    // Mode 1: lower band mirrors even bars, odd bars black; upper band = mode 0.
    exp_pix.delete();
    exp_pix[0]   = 3'b001;  exp_pix[36]  = 3'b000;
    exp_pix[40]  = 3'b000;  exp_pix[80]  = 3'b101;
    exp_pix[110] = 3'b000;  exp_pix[150] = 3'b011;
    exp_pix[220] = 3'b111;  exp_pix[255] = 3'b111;
    sweep_line(170, "m1");
    load_mode0_table();
    sweep_line(100, "m1");

    // Back-to-back requests, each acked; the later one (2) wins.
    drive(1'b0, 1'b0, 0, 30, 1'b1, 2'd3);
    push("b2b_ack_a", K_ACK, 8'd1);
    drive(1'b0, 1'b0, 0, 30, 1'b1, 2'd2);
    push("b2b_ack_b", K_ACK, 8'd1);
    drive(1'b0, 1'b0, 0, 30, 1'b0, 2'd0);
    push("b2b_ack_drop", K_ACK, 8'd0);
    push("b2b_mode_held", K_MODE, 8'd1);
    frame_end(1'b0, 2'd0, 2'd1, 2'd2, 8'd2);

    // Mode 2 checkerboard, phase 0.
    pixel(0, 0, 3'b000, "chk_f2");
    pixel(8, 0, 3'b111, "chk_f2");
    drive(1'b0, 1'b0, 8, 0, 1'b0, 2'd0);
    push("chk_blank", K_RGB, 8'd0);
    for (int f = 3; f <= 15; f++) frame_end(1'b0, 2'd0, 2'd2, 2'd2, 8'(f));
    pixel(0, 0, 3'b000, "chk_f15");
    pixel(8, 0, 3'b111, "chk_f15");
    frame_end(1'b0, 2'd0, 2'd2, 2'd2, 8'd16);
    pixel(0, 0, 3'b111, "chk_f16");
    pixel(8, 0, 3'b000, "chk_f16");
    pixel(8, 8, 3'b111, "chk_f16");

    // Reset mid-line in mode 2, with a request present.
    drive(1'b0, 1'b1, 100, 50, 1'b1, 2'd1);
    drive(1'b1, 1'b1, 101, 50, 1'b1, 2'd1);
    push("midrst_rgb", K_RGB, 8'd0);
    push("midrst_ack", K_ACK, 8'd0);
    push("midrst_mode", K_MODE, 8'd0);
    push("midrst_frame", K_FRAME, 8'd0);
    pixel(0, 0, 3'b111, "resume_m0");

    // Request arriving on the frame-end pixel itself switches to mode 3.
    frame_end(1'b1, 2'd3, 2'd0, 2'd3, 8'd1);

    // Crosshair: column follows cross_x (= frames since reset), row 120 white.
    load_cross_table(1, 1'b0);
    sweep_line(5, "x_f1");
    load_cross_table(0, 1'b1);
    sweep_line(120, "x_row");
    frame_end(1'b0, 2'd0, 2'd3, 2'd3, 8'd2);
    load_cross_table(2, 1'b0);
    sweep_line(5, "x_f2");
    frame_end(1'b0, 2'd0, 2'd3, 2'd3, 8'd3);
    load_cross_table(3, 1'b0);
    sweep_line(5, "x_f3");

    // Run to the 256-frame wrap of both frame_count and cross_x.
    for (int f = 4; f <= 255; f++) frame_end(1'b0, 2'd0, 2'd3, 2'd3, 8'(f));
    pixel(255, 5, 3'b111, "x_f255");
    pixel(254, 5, 3'b000, "x_f255");
    pixel(0,   5, 3'b000, "x_f255");
    frame_end(1'b0, 2'd0, 2'd3, 2'd3, 8'd0);
    pixel(0,   5, 3'b111, "x_wrap");
    pixel(1,   5, 3'b000, "x_wrap");
    pixel(255, 5, 3'b000, "x_wrap");
    pixel(77, 120, 3'b111, "x_wrap");

    drive(1'b0, 1'b0, 0, 0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 2'd0);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
